// File: rtl/pb_pkg.sv
// Shared protobuf wire-format constants and the deserializer state encoding.
package pb_pkg;

    localparam logic [2:0] WT_VARINT = 3'd0;
    localparam logic [2:0] WT_I64    = 3'd1;
    localparam logic [2:0] WT_LEN    = 3'd2;
    localparam logic [2:0] WT_I32    = 3'd5;

    localparam logic [3:0] TAG_MAX_BYTES = 4'd5;
    localparam logic [3:0] VAL_MAX_BYTES = 4'd10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TAG,
        ST_VARINT,
        ST_FIXED,
        ST_LEN,
        ST_EMIT,
        ST_PAYLOAD,
        ST_DONE,
        ST_ERROR
    } state_e;

    function automatic logic wt_supported(input logic [2:0] wt);
        return (wt == WT_VARINT) || (wt == WT_I64) || (wt == WT_LEN) || (wt == WT_I32);
    endfunction

endpackage

// File: rtl/varint_accum.sv
// 64-bit shift-OR varint accumulator; acc_next includes the byte currently presented.
module varint_accum
    import pb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        step,
    input  logic [7:0]  in_byte,
    input  logic [3:0]  max_bytes,
    output logic [63:0] acc_next,
    output logic        cont,
    output logic        overflow
);

    logic [63:0] acc_q, acc_d;
    logic [3:0]  idx_q, idx_d;
    logic [6:0]  shift;

    always_comb begin
        shift    = {3'b000, idx_q} * 7'd7;
        // Shifts of 64 or more yield zero, so bits past bit 63 simply fall off.
        acc_next = acc_q | ({57'd0, in_byte[6:0]} << shift);
        cont     = in_byte[7];
        overflow = step && (idx_q >= max_bytes);
        acc_d    = acc_q;
        idx_d    = idx_q;
        if (clear || (step && !in_byte[7])) begin
            acc_d = '0;
            idx_d = '0;
        end else if (step) begin
            acc_d = acc_next;
            idx_d = (idx_q == 4'hF) ? idx_q : idx_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            idx_q <= '0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/deser_field.sv
// Protobuf wire-format field deserializer: tag/value decode plus payload pass-through.
// Optional malformed-input detection is enabled by defining DESER_ERR_CHECK_EN.
module deser_field
    import pb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] msg_len,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        field_valid,
    input  logic        field_ready,
    output logic [28:0] field_id,
    output logic [2:0]  wire_type,
    output logic [63:0] value,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    input  logic        pl_ready,
    output logic        pl_last,
    output logic        busy,
    output logic        done,
    output logic        error,
    output state_e      dbg_state
);

    // A transfer handshakes when valid & ready are both high at the rising edge;
    // field_valid and its data are held unchanged until field_ready is seen.

`ifdef DESER_ERR_CHECK_EN
    localparam state_e MID_END_ST = ST_ERROR;
`else
    localparam state_e MID_END_ST = ST_DONE;
`endif

    state_e      state_q, state_d;
    logic [31:0] msg_len_q, msg_len_d;
    logic [31:0] byte_cnt_q, byte_cnt_d;
    logic [28:0] field_id_q, field_id_d;
    logic [2:0]  wire_type_q, wire_type_d;
    logic [63:0] value_q, value_d;
    logic [63:0] rem_q, rem_d;
    logic [2:0]  fix_cnt_q, fix_cnt_d;
    logic [2:0]  fix_max_q, fix_max_d;

    logic        take;
    logic        msg_end;
    logic        va_clear, va_step, va_cont, va_overflow;
    logic [3:0]  va_max;
    logic [63:0] va_acc_next;
    logic [28:0] tag_id;
    logic [2:0]  tag_wt;

    always_comb begin
        case (state_q)
            ST_TAG, ST_VARINT, ST_FIXED, ST_LEN: in_ready = 1'b1;
            ST_PAYLOAD:                          in_ready = pl_ready;
            default:                             in_ready = 1'b0;
        endcase
    end

    assign take     = in_valid && in_ready;
    assign msg_end  = (byte_cnt_q + 32'd1) == msg_len_q;
    assign va_clear = (state_q == ST_IDLE);
    assign va_step  = take && ((state_q == ST_TAG) || (state_q == ST_VARINT) || (state_q == ST_LEN));
    assign va_max   = (state_q == ST_TAG) ? TAG_MAX_BYTES : VAL_MAX_BYTES;
    assign tag_id   = va_acc_next[31:3];
    assign tag_wt   = va_acc_next[2:0];

    varint_accum u_varint (
        .clk       (clk),
        .reset     (reset),
        .clear     (va_clear),
        .step      (va_step),
        .in_byte   (in_byte),
        .max_bytes (va_max),
        .acc_next  (va_acc_next),
        .cont      (va_cont),
        .overflow  (va_overflow)
    );

    always_comb begin
        state_d     = state_q;
        msg_len_d   = msg_len_q;
        byte_cnt_d  = byte_cnt_q;
        field_id_d  = field_id_q;
        wire_type_d = wire_type_q;
        value_d     = value_q;
        rem_d       = rem_q;
        fix_cnt_d   = fix_cnt_q;
        fix_max_d   = fix_max_q;
        if (take) byte_cnt_d = byte_cnt_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    msg_len_d  = msg_len;
                    byte_cnt_d = '0;
                    state_d    = (msg_len == 32'd0) ? ST_DONE : ST_TAG;
                end
            end
            ST_TAG: begin
                if (take && !va_cont) begin
                    field_id_d  = tag_id;
                    wire_type_d = tag_wt;
                    value_d     = '0;
                    fix_cnt_d   = '0;
                    case (tag_wt)
                        WT_VARINT: state_d = ST_VARINT;
                        WT_LEN:    state_d = ST_LEN;
                        WT_I64: begin
                            state_d   = ST_FIXED;
                            fix_max_d = 3'd7;
                        end
                        WT_I32: begin
                            state_d   = ST_FIXED;
                            fix_max_d = 3'd3;
                        end
                        // Unknown types carry no body: emit immediately with value 0.
                        default:   state_d = ST_EMIT;
                    endcase
                    if (wt_supported(tag_wt) && msg_end) state_d = MID_END_ST;
`ifdef DESER_ERR_CHECK_EN
                    if (!wt_supported(tag_wt) || (tag_id == '0)) state_d = ST_ERROR;
`endif
                end else if (take && msg_end) begin
                    state_d = MID_END_ST;
                end
            end
            ST_VARINT: begin
                if (take) begin
                    if (!va_cont) begin
                        value_d = va_acc_next;
                        state_d = ST_EMIT;
                    end else if (msg_end) begin
                        state_d = MID_END_ST;
                    end
                end
            end
            ST_LEN: begin
                if (take) begin
                    if (!va_cont) begin
                        value_d = va_acc_next;
                        state_d = ((va_acc_next != 64'd0) && msg_end) ? MID_END_ST : ST_EMIT;
                    end else if (msg_end) begin
                        state_d = MID_END_ST;
                    end
                end
            end
            ST_FIXED: begin
                if (take) begin
                    value_d   = value_q | ({56'd0, in_byte} << {fix_cnt_q, 3'b000});
                    fix_cnt_d = fix_cnt_q + 3'd1;
                    if (fix_cnt_q == fix_max_q) state_d = ST_EMIT;
                    else if (msg_end)           state_d = MID_END_ST;
                end
            end
            ST_EMIT: begin
                if (field_ready) begin
                    if ((wire_type_q == WT_LEN) && (value_q != 64'd0)) begin
                        rem_d   = value_q;
                        state_d = ST_PAYLOAD;
                    end else if (byte_cnt_q == msg_len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_TAG;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (take) begin
                    rem_d = rem_q - 64'd1;
                    if (rem_q == 64'd1) state_d = msg_end ? ST_DONE : ST_TAG;
                    else if (msg_end)   state_d = MID_END_ST;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = state_q;
        endcase

`ifdef DESER_ERR_CHECK_EN
        if (va_overflow) state_d = ST_ERROR;
`endif
    end

`ifndef DESER_ERR_CHECK_EN
    logic unused_overflow;
    assign unused_overflow = va_overflow;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            msg_len_q   <= '0;
            byte_cnt_q  <= '0;
            field_id_q  <= '0;
            wire_type_q <= '0;
            value_q     <= '0;
            rem_q       <= '0;
            fix_cnt_q   <= '0;
            fix_max_q   <= '0;
        end else begin
            state_q     <= state_d;
            msg_len_q   <= msg_len_d;
            byte_cnt_q  <= byte_cnt_d;
            field_id_q  <= field_id_d;
            wire_type_q <= wire_type_d;
            value_q     <= value_d;
            rem_q       <= rem_d;
            fix_cnt_q   <= fix_cnt_d;
            fix_max_q   <= fix_max_d;
        end
    end

    assign field_valid = (state_q == ST_EMIT);
    assign field_id    = field_id_q;
    assign wire_type   = wire_type_q;
    assign value       = value_q;
    assign pl_data     = in_byte;
    assign pl_valid    = (state_q == ST_PAYLOAD) && in_valid;
    assign pl_last     = (state_q == ST_PAYLOAD) && (rem_q == 64'd1);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
`ifdef DESER_ERR_CHECK_EN
    assign error       = (state_q == ST_ERROR);
`else
    assign error       = 1'b0;
`endif
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_deser_field.sv
// Self-checking bench for deser_field: directed wire-format vectors plus random messages
// scored against a software parser of the byte stream.
module tb_deser_field;
    import pb_pkg::*;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] msg_len;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        field_valid;
    logic        field_ready;
    logic [28:0] field_id;
    logic [2:0]  wire_type;
    logic [63:0] value;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic        pl_last;
    logic        busy;
    logic        done;
    logic        error;
    state_e      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  msg_q[$];
    logic [95:0] exp_q[$];
    logic [8:0]  exp_pl_q[$];

    int p_in    = 100;
    int p_fr    = 100;
    int p_pl    = 100;
    int fr_hold = 0;

    deser_field dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .msg_len     (msg_len),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .field_valid (field_valid),
        .field_ready (field_ready),
        .field_id    (field_id),
        .wire_type   (wire_type),
        .value       (value),
        .pl_data     (pl_data),
        .pl_valid    (pl_valid),
        .pl_ready    (pl_ready),
        .pl_last     (pl_last),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] pack_f(input logic [28:0] id, input logic [2:0] wt, input logic [63:0] v);
        return {id, wt, v};
    endfunction

    // ---------------- reference model: sequential parse of the byte stream ----------------
    task automatic read_varint(input int n, inout int p, output logic [63:0] val, output bit ok);
        int k;
        logic [7:0] b;
        k = 0;
        val = '0;
        ok = 1'b0;
        while (p < n) begin
            b = msg_q[p];
            p++;
            if (k < 10) val = val | (64'(b[6:0]) << (7 * k));
            k++;
            if (!b[7]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic model_decode(input int n);
        int p;
        int nb;
        bit ok;
        logic [63:0] tag, v, len;
        p = 0;
        while (p < n) begin
            read_varint(n, p, tag, ok);
            if (!ok) break;
            if (tag[2:0] == 3'd0) begin
                read_varint(n, p, v, ok);
                if (!ok) break;
                exp_q.push_back(pack_f(tag[31:3], tag[2:0], v));
            end else if (tag[2:0] == 3'd1 || tag[2:0] == 3'd5) begin
                nb = (tag[2:0] == 3'd1) ? 8 : 4;
                if (p + nb > n) break;
                v = '0;
                for (int i = 0; i < nb; i++) v = v | (64'(msg_q[p + i]) << (8 * i));
                p += nb;
                exp_q.push_back(pack_f(tag[31:3], tag[2:0], v));
            end else if (tag[2:0] == 3'd2) begin
                read_varint(n, p, len, ok);
                if (!ok) break;
                if (len != 0 && p >= n) break;
                exp_q.push_back(pack_f(tag[31:3], tag[2:0], len));
                for (longint i = 0; i < longint'(len) && p < n; i++) begin
                    exp_pl_q.push_back({(i == longint'(len) - 1), msg_q[p]});
                    p++;
                end
            end else begin
                exp_q.push_back(pack_f(tag[31:3], tag[2:0], 64'd0));
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic put_varint(input logic [63:0] v);
        logic [63:0] r;
        r = v;
        do begin
            msg_q.push_back({(r >> 7) != 64'd0, r[6:0]});
            r = r >> 7;
        end while (r != 64'd0);
    endtask

    function automatic bit roll(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        check_eq("reset_ctrl", 96'({in_ready, field_valid, pl_valid, pl_last, busy, done, error}), 96'd0);
        check_eq("reset_field", 96'({field_id, wire_type, value}), 96'd0);
        check_eq("reset_state", 96'(dbg_state), 96'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        field_ready = 1'b0;
        pl_ready = 1'b0;
    endtask

    task automatic run_msg(input int n, input bit use_model, input bit abort_pl, input bit exp_err);
        int idx, cyc, last_ev, last_take, fv_run;
        bit fin, err_seen, prev_hold;
        logic [95:0] prev_f, cur_f;
        if (use_model) begin
            exp_q.delete();
            exp_pl_q.delete();
            model_decode(n);
        end
        idx = 0; cyc = 0; last_ev = 0; last_take = -100; fv_run = 0;
        fin = 1'b0; err_seen = 1'b0; prev_hold = 1'b0; prev_f = '0;
        while (!fin && cyc < 800) begin
            @(negedge clk);
            en = (cyc == 0);
            msg_len = n;
            in_valid = (cyc > 0) && (idx < n) && roll(p_in);
            in_byte = (idx < n) ? msg_q[idx] : 8'h00;
            field_ready = (fv_run >= fr_hold) && roll(p_fr);
            pl_ready = roll(p_pl);
            #1;
            cur_f = {field_id, wire_type, value};
            if (prev_hold) begin
                check_eq("fv_held", 96'(field_valid), 96'd1);
                check_eq("field_stable", cur_f, prev_f);
            end
            if (field_valid) check_eq("in_ready_in_emit", 96'(in_ready), 96'd0);
            if (pl_valid) check_eq("pl_ready_pass", 96'(in_ready), 96'(pl_ready));
            if (field_valid && fv_run == 0) check_eq("fv_latency", 96'(cyc - last_take), 96'd1);
            if (in_valid && in_ready) begin
                if (pl_valid) begin
                    check_eq("pl_expected", 96'(exp_pl_q.size() != 0), 96'd1);
                    if (exp_pl_q.size() != 0) check_eq("pl_byte", 96'({pl_last, pl_data}), 96'(exp_pl_q.pop_front()));
                end
                idx++;
                last_ev = cyc;
                last_take = cyc;
            end
            if (field_valid && field_ready) begin
                check_eq("field_expected", 96'(exp_q.size() != 0), 96'd1);
                if (exp_q.size() != 0) check_eq("field", cur_f, exp_q.pop_front());
                last_ev = cyc;
            end
            prev_hold = field_valid && !field_ready;
            prev_f = cur_f;
            fv_run = field_valid ? fv_run + 1 : 0;
            if (done) begin
                check_eq("done_timing", 96'(cyc - last_ev), 96'd1);
                fin = 1'b1;
            end
            if (error) begin
                err_seen = 1'b1;
                fin = 1'b1;
            end
            if (abort_pl && pl_valid) fin = 1'b1;
            cyc++;
        end
        check_eq("finished", 96'(fin), 96'd1);
        if (!abort_pl) begin
            check_eq("error_seen", 96'(err_seen), 96'(exp_err));
            check_eq("fields_left", 96'(exp_q.size()), 96'd0);
            if (!exp_err) begin
                check_eq("consumed", 96'(idx), 96'(n));
                check_eq("pl_left", 96'(exp_pl_q.size()), 96'd0);
                @(negedge clk);
                en = 1'b0;
                in_valid = 1'b0;
                #1;
                check_eq("idle_after_done", 96'({busy, done}), 96'd0);
            end
        end
    endtask

    task automatic clear_exp();
        exp_q.delete();
        exp_pl_q.delete();
    endtask

    task automatic build_random(output int n);
        int nf, r, id, len;
        logic [2:0] wt;
        logic [63:0] v;
        msg_q.delete();
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) begin
            id = $urandom_range(1, 3000);
            r = $urandom_range(0, 9);
            if (r < 3)      wt = WT_VARINT;
            else if (r < 5) wt = WT_LEN;
            else if (r < 6) wt = WT_I64;
            else if (r < 8) wt = WT_I32;
`ifdef DESER_ERR_CHECK_EN
            else            wt = WT_VARINT;
`else
            else            wt = (r == 8) ? 3'd3 : 3'd6;
`endif
            put_varint((64'(id) << 3) | 64'(wt));
            if (wt == WT_VARINT) begin
                v = {$urandom(), $urandom()};
                put_varint(v >> $urandom_range(0, 63));
            end else if (wt == WT_I64) begin
                for (int i = 0; i < 8; i++) msg_q.push_back(8'($urandom()));
            end else if (wt == WT_I32) begin
                for (int i = 0; i < 4; i++) msg_q.push_back(8'($urandom()));
            end else if (wt == WT_LEN) begin
                len = $urandom_range(0, 4);
                put_varint(64'(len));
                for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom()));
            end
        end
        n = msg_q.size();
`ifndef DESER_ERR_CHECK_EN
        if ($urandom_range(0, 3) == 0) n = $urandom_range(0, n);
`endif
    endtask

    initial begin
        int n;
        reset = 1'b1; en = 1'b0; msg_len = '0; in_byte = '0;
        in_valid = 1'b0; field_ready = 1'b0; pl_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // simple varint field
        msg_q = '{8'h08, 8'h96, 8'h01};
        clear_exp();
        exp_q.push_back(pack_f(29'd1, 3'd0, 64'd150));
        run_msg(3, 1'b0, 1'b0, 1'b0);

        // length-delimited field with payload
        msg_q = '{8'h12, 8'h03, 8'h61, 8'h62, 8'h63};
        clear_exp();
        exp_q.push_back(pack_f(29'd2, 3'd2, 64'd3));
        exp_pl_q.push_back({1'b0, 8'h61});
        exp_pl_q.push_back({1'b0, 8'h62});
        exp_pl_q.push_back({1'b1, 8'h63});
        run_msg(5, 1'b0, 1'b0, 1'b0);

        // fixed32 field
        msg_q = '{8'h1D, 8'h01, 8'h00, 8'h00, 8'h80};
        clear_exp();
        exp_q.push_back(pack_f(29'd3, 3'd5, 64'h8000_0001));
        run_msg(5, 1'b0, 1'b0, 1'b0);

        // two back-to-back varint fields
        msg_q = '{8'h08, 8'h01, 8'h18, 8'h02};
        clear_exp();
        exp_q.push_back(pack_f(29'd1, 3'd0, 64'd1));
        exp_q.push_back(pack_f(29'd3, 3'd0, 64'd2));
        run_msg(4, 1'b0, 1'b0, 1'b0);

        // empty message: done one cycle after en
        msg_q.delete();
        clear_exp();
        run_msg(0, 1'b0, 1'b0, 1'b0);

        // backpressure on both consumer sides
        fr_hold = 5; p_pl = 30; p_in = 70; p_fr = 100;
        msg_q = '{8'h12, 8'h03, 8'h61, 8'h62, 8'h63};
        clear_exp();
        exp_q.push_back(pack_f(29'd2, 3'd2, 64'd3));
        exp_pl_q.push_back({1'b0, 8'h61});
        exp_pl_q.push_back({1'b0, 8'h62});
        exp_pl_q.push_back({1'b1, 8'h63});
        run_msg(5, 1'b0, 1'b0, 1'b0);
        msg_q = '{8'h1D, 8'h01, 8'h00, 8'h00, 8'h80};
        clear_exp();
        exp_q.push_back(pack_f(29'd3, 3'd5, 64'h8000_0001));
        run_msg(5, 1'b0, 1'b0, 1'b0);
        fr_hold = 0; p_pl = 100; p_in = 100;

        // overlong value varint: tag 08, eleven FF, then 01 and a second field 08 01
        msg_q = '{8'h08};
        repeat (11) msg_q.push_back(8'hFF);
        msg_q.push_back(8'h01);
        msg_q.push_back(8'h08);
        msg_q.push_back(8'h01);
        clear_exp();
`ifdef DESER_ERR_CHECK_EN
        run_msg(15, 1'b0, 1'b0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte = 8'h08;
            field_ready = 1'b1;
            #1;
            check_eq("error_sticky", 96'({error, in_ready, field_valid}), 96'b100);
        end
        do_reset();
`else
        exp_q.push_back(pack_f(29'd1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF));
        exp_q.push_back(pack_f(29'd1, 3'd0, 64'd1));
        run_msg(15, 1'b0, 1'b0, 1'b0);
`endif

        // reset in the middle of a payload, then a clean decode
        p_pl = 50;
        msg_q = '{8'h12, 8'h05, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        run_msg(7, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b1;
        do_reset();
        p_pl = 100;
        msg_q = '{8'h08, 8'h96, 8'h01};
        clear_exp();
        exp_q.push_back(pack_f(29'd1, 3'd0, 64'd150));
        run_msg(3, 1'b0, 1'b0, 1'b0);

        // random messages against the reference parser
        for (int m = 0; m < 40; m++) begin
            p_in = $urandom_range(40, 100);
            p_fr = $urandom_range(30, 100);
            p_pl = $urandom_range(30, 100);
            fr_hold = $urandom_range(0, 2);
            build_random(n);
            run_msg(n, 1'b1, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
